// File: rtl/imm_encode_pkg.sv
// Shared definitions for the immediate encoder.
// Holds the ImmSrc mode codes, which match the codes the immediate extender uses,
// the encoder FSM state type, and the last rotation value the search tries.
package imm_encode_pkg;

  typedef enum logic [1:0] {
    IMM8     = 2'b00,
    IMM12    = 2'b01,
    BRANCH24 = 2'b10,
    ROTIMM   = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  localparam logic [3:0] ROT_MAX = 4'd15;

endpackage

// File: rtl/imm_rot_check.sv
// Combinational test of one rotation candidate for the rotated-imm8 mode.
// Ports:
//   Value  in  32  constant being encoded
//   rot    in   4  candidate rotation; the shift amount is 2*rot
//   match  out  1  (Value ROL 2*rot) fits in 8 bits
//   imm8   out  8  low byte of the rotated value
module imm_rot_check (
  input  logic [31:0] Value,
  input  logic [3:0]  rot,
  output logic        match,
  output logic [7:0]  imm8
);

  logic [5:0]  sh;
  logic [31:0] rotated;

  always_comb begin
    sh = {1'b0, rot, 1'b0};
    // A right shift by 32 yields zero, so rot=0 leaves Value unchanged.
    rotated = (Value << sh) | (Value >> (6'd32 - sh));
    match   = (rotated[31:8] == 24'h000000);
    imm8    = rotated[7:0];
  end

endmodule

// File: rtl/imm_encode.sv
// Encodes a 32-bit constant into a 24-bit instruction immediate field.
// Modes 00/01/10 are decided in the acceptance cycle; mode 11 searches rotations
// 0..15, one per cycle, and the lowest matching rotation wins.
// Ports:
//   clk     in   1  clock, rising edge
//   reset   in   1  synchronous, active-high
//   start   in   1  request pulse, honoured only in IDLE
//   ImmSrc  in   2  encoding mode
//   Value   in  32  constant to encode, captured with start
//   busy    out  1  high while searching rotations
//   done    out  1  one-cycle completion pulse
//   ok      out  1  result encodable; held until the next completion
//   Field   out 24  encoded immediate bits; zero whenever ok=0
module imm_encode
  import imm_encode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Value,
  output logic        busy,
  output logic        done,
  output logic        ok,
  output logic [23:0] Field
);

  state_e      state_q, state_d;
  logic [3:0]  rot_q, rot_d;
  logic [31:0] value_q, value_d;
  logic        ok_q, ok_d;
  logic [23:0] field_q, field_d;

  logic        rot_match;
  logic [7:0]  rot_imm8;
  logic        fits;

  imm_rot_check u_rot_check (
    .Value (value_q),
    .rot   (rot_q),
    .match (rot_match),
    .imm8  (rot_imm8)
  );

  always_comb begin
    state_d = state_q;
    rot_d   = rot_q;
    value_d = value_q;
    ok_d    = ok_q;
    field_d = field_q;
    fits    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          value_d = Value;
          rot_d   = 4'd0;
          unique case (imm_src_e'(ImmSrc))
            IMM8: begin
              fits    = (Value[31:8] == 24'h000000);
              state_d = DONE;
              ok_d    = fits;
              field_d = fits ? {16'h0000, Value[7:0]} : 24'h000000;
            end
            IMM12: begin
              fits    = (Value[31:12] == 20'h00000);
              state_d = DONE;
              ok_d    = fits;
              field_d = fits ? {12'h000, Value[11:0]} : 24'h000000;
            end
            BRANCH24: begin
              // Word aligned and bits 31:25 are a sign extension of bit 25.
              fits    = (Value[1:0] == 2'b00) &&
                        ((Value[31:25] == 7'h00) || (Value[31:25] == 7'h7f));
              state_d = DONE;
              ok_d    = fits;
              field_d = fits ? Value[25:2] : 24'h000000;
            end
            ROTIMM: begin
              state_d = SEARCH;
            end
          endcase
        end
      end
      SEARCH: begin
        if (rot_match) begin
          state_d = DONE;
          ok_d    = 1'b1;
          field_d = {12'h000, rot_q, rot_imm8};
        end else if (rot_q == ROT_MAX) begin
          state_d = DONE;
          ok_d    = 1'b0;
          field_d = 24'h000000;
        end else begin
          rot_d = rot_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rot_q   <= 4'd0;
      value_q <= 32'h0000_0000;
      ok_q    <= 1'b0;
      field_q <= 24'h000000;
    end else begin
      state_q <= state_d;
      rot_q   <= rot_d;
      value_q <= value_d;
      ok_q    <= ok_d;
      field_q <= field_d;
    end
  end

  assign busy  = (state_q == SEARCH);
  assign done  = (state_q == DONE);
  assign ok    = ok_q;
  assign Field = field_q;

endmodule

// File: doc/imm_encode.md
IMM_ENCODE -- requirements
Module: imm_encode

Interface
REQ-001 The module SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- ImmSrc  in  2  encoding mode: 00 imm8, 01 imm12, 10 branch24, 11 rotated imm8
- Value  in  32  constant to encode; captured with start
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle completion pulse
- ok  out  1  result valid/encodable; meaningful when done=1, held afterwards
- Field  out  24  encoded instruction immediate bits [23:0]; held after done
REQ-002 The module SHALL have no parameters; all widths SHALL be fixed as listed in REQ-001.

Function
REQ-003 The FSM SHALL have states IDLE, SEARCH and DONE.
REQ-004 In IDLE, start=1 SHALL capture Value and ImmSrc and SHALL move to DONE for modes 00/01/10, or to SEARCH with rot=0 for mode 11.
REQ-005 start SHALL be ignored while busy=1; captured operands SHALL NOT change until the next acceptance.
REQ-006 Mode 00: ok=1 iff Value[31:8]==0; Field={16'b0,Value[7:0]}.
REQ-007 Mode 01: ok=1 iff Value[31:12]==0; Field={12'b0,Value[11:0]}.
REQ-008 Mode 10: ok=1 iff Value[1:0]==0 and Value[31:25] are all equal; Field=Value[25:2].
REQ-009 Mode 11: each SEARCH cycle SHALL test one rot (0..15); match iff (Value rotated left by 2*rot)[31:8]==0.
REQ-010 On a match, the module SHALL go to DONE with ok=1 and Field={12'b0,rot[3:0],imm8}, where imm8=(Value ROL 2*rot)[7:0].
REQ-011 The lowest matching rot SHALL win; Value 0 SHALL encode as rot=0, imm8=0.
REQ-012 With no match at rot=15, the module SHALL go to DONE with ok=0.
REQ-013 Whenever ok=0, Field SHALL be 24'h000000.
REQ-014 DONE SHALL last exactly one cycle, with done=1 and busy=0, then return to IDLE.
REQ-015 A start asserted in the DONE cycle SHALL be ignored.
REQ-016 Latency, counting the acceptance cycle as cycle 0:
- modes 00/01/10: done at cycle 1
- mode 11, match at rot r: done at cycle r+2
- mode 11, no match: done at cycle 17
REQ-017 busy SHALL be 1 exactly while in SEARCH.
REQ-018 ok and Field SHALL update only on entry to DONE and hold until the next DONE.
REQ-019 The rot counter SHALL be 4 bits and SHALL NOT wrap; rot=15 without a match terminates the search.

Reset
REQ-020 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, ok=0, Field=0 and rot=0.
REQ-021 reset SHALL take priority over start and over all state transitions.
REQ-022 Reset during SEARCH SHALL abort the operation with no done pulse.
REQ-023 After reset deasserts, a start SHALL be accepted in the first cycle it is sampled in IDLE.

Structure
REQ-024 A shared package SHALL hold the ImmSrc codes (IMM8, IMM12, BRANCH24, ROTIMM), the state enum {IDLE, SEARCH, DONE} and the constant ROT_MAX=15.
REQ-025 The package ImmSrc codes SHALL be the same ones used by the processor's immediate extender.
REQ-026 A combinational sub-module imm_rot_check SHALL take (Value, rot) and return (match, imm8).
REQ-027 The FSM, counter and output registers SHALL reside in imm_encode.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Mode 11, Value 0x000000FF -> done at cycle 2, ok=1, Field 0x0000FF.
- Mode 11, Value 0xF000000F -> done at cycle 4, ok=1, Field 0x0002FF.
- Mode 11, Value 0xFF000000 -> done at cycle 6, ok=1, Field 0x0004FF.
- Mode 11, Value 0x00000102 -> busy for cycles 1..16, done at cycle 17, ok=0, Field 0.
- Mode 10, Value 0xFFFFFFF8 -> done at cycle 1, ok=1, Field 0xFFFFFE.
- Mode 10, Value 0x00000006 -> ok=0.
- Mode 00, Value 0x100 -> ok=0.
- Mode 11, Value 0x00000102, reset at cycle 3 -> no done pulse; busy=0 and all outputs 0 on the next cycle.
- Mode 11, start re-pulsed at cycle 2 while busy -> ignored; original result unchanged.
REQ-029 The bench SHALL check every ok=1 result by decoding Field back through the extender's rules and comparing to Value.
